// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush controller: prioritised per-stage hold plus a one-cycle exception redirect.
// Optional stall watchdog is built only when STALL_WDOG_EN is defined.
module stall_flush_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h00000020,
    parameter logic [7:0]  WDOG_LIMIT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        wdog_timeout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    localparam logic [31:0] EXC_ERET = 32'h0000000e;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_target;
    logic [31:0] w_target_nxt;
    logic [5:0]  w_stall;
    logic        w_accept;

    // Per-stage hold; SETTLE only honours a bus wait while the redirected fetch lands.
    always_comb begin
        w_stall = 6'b000000;
        if (!rst) begin
            w_stall = 6'b000000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (stallreq_mem) begin
                        w_stall = 6'b011111;
                    end else if (stallreq_ex) begin
                        w_stall = 6'b001111;
                    end else if (stallreq_id) begin
                        w_stall = 6'b000111;
                    end else begin
                        w_stall = 6'b000000;
                    end
                end
                ST_SETTLE: begin
                    if (stallreq_mem) begin
                        w_stall = 6'b011111;
                    end else begin
                        w_stall = 6'b000000;
                    end
                end
                default: w_stall = 6'b000000;
            endcase
        end
    end

    // An exception waits until the memory stage is no longer holding the bus.
    assign w_accept = (r_state == ST_IDLE) && (excepttype_i != 32'h00000000) && !stallreq_mem;

    // Next-state and redirect target selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_FLUSH;
                    if (excepttype_i == EXC_ERET) begin
                        w_target_nxt = cp0_epc_i;
                    end else begin
                        w_target_nxt = EXC_VECTOR;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH:  w_state_nxt = ST_SETTLE;
            ST_SETTLE: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State and target registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_target <= 32'h00000000;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
        end
    end

    assign stall  = w_stall;
    assign flush  = (r_state == ST_FLUSH);
    assign new_pc = (r_state == ST_FLUSH) ? r_target : 32'h00000000;

`ifdef STALL_WDOG_EN
    logic [7:0] r_wdog_cnt;
    logic       w_wdog_hit;

    // The pulse lands on the stalled cycle that completes WDOG_LIMIT in a row.
    assign w_wdog_hit = (w_stall != 6'b000000) && (r_wdog_cnt == (WDOG_LIMIT - 8'd1));

    // Consecutive-stall counter, restarting after each timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog_cnt <= 8'd0;
        end else if ((w_stall == 6'b000000) || w_wdog_hit) begin
            r_wdog_cnt <= 8'd0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + 8'd1;
        end
    end

    assign wdog_timeout = w_wdog_hit;
`else
    assign wdog_timeout = 1'b0;
`endif

endmodule
